// File: rtl/tl_vc_arbiter.sv
// tl_vc_arbiter
//   Round-robin scheduler between the four transaction-layer source FIFOs
//   (fifo1..fifo4) and the four destination FIFOs (fifo5..fifo8). Each
//   ACTIVE cycle it pops at most one eligible source head and pushes that
//   word one cycle later into the destination FIFO selected by the word's top
//   two bits. It also holds the almost-full/almost-empty thresholds loaded
//   during INIT.
//
// Ports
//   clk, reset_L               clock, asynchronous active-low reset
//   init                       configuration request (level)
//   umbral_IN_H / umbral_IN_L  thresholds to load while in INIT
//   src_empty, src_data        empty flags and FWFT head words of fifo1..fifo4
//   dst_almost_full, dst_full  status of fifo5..fifo8
//   src_pop                    one-hot pop strobe (combinational)
//   dst_push, dst_data         one-hot push strobe and word (registered)
//   umbral_H_out/umbral_L_out  active thresholds
//   state_out, active_out, idle_out, error_out  FSM state and status

module tl_vc_arbiter #(
    parameter int WORD_SIZE  = 10,
    parameter int PTR_L      = 3,
    parameter int FIFO_UNITS = 4
) (
    input  logic                            clk,
    input  logic                            reset_L,
    input  logic                            init,
    input  logic [PTR_L-1:0]                umbral_IN_H,
    input  logic [PTR_L-1:0]                umbral_IN_L,
    input  logic [FIFO_UNITS-1:0]           src_empty,
    input  logic [FIFO_UNITS*WORD_SIZE-1:0] src_data,
    input  logic [FIFO_UNITS-1:0]           dst_almost_full,
    input  logic [FIFO_UNITS-1:0]           dst_full,
    output logic [FIFO_UNITS-1:0]           src_pop,
    output logic [FIFO_UNITS-1:0]           dst_push,
    output logic [WORD_SIZE-1:0]            dst_data,
    output logic [PTR_L-1:0]                umbral_H_out,
    output logic [PTR_L-1:0]                umbral_L_out,
    output logic [1:0]                      state_out,
    output logic                            active_out,
    output logic                            idle_out,
    output logic                            error_out
);

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    localparam logic [PTR_L-1:0] UMBRAL_H_RST = PTR_L'(6);
    localparam logic [PTR_L-1:0] UMBRAL_L_RST = PTR_L'(1);

    function automatic logic [FIFO_UNITS-1:0] onehot(input logic [1:0] idx);
        logic [FIFO_UNITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [1:0]            ptr;
    logic [1:0]            cls [FIFO_UNITS];
    logic [FIFO_UNITS-1:0] elig;
    logic                  grant_vld;
    logic [1:0]            grant_idx;
    logic [WORD_SIZE-1:0]  grant_word;
    logic                  cfg_valid;
    logic                  err_set;

    // Per-source destination class and eligibility. A source whose target is
    // almost full is skipped without stalling the others.
    always_comb begin
        for (int i = 0; i < FIFO_UNITS; i++) begin
            cls[i]  = src_data[i*WORD_SIZE + WORD_SIZE - 2 +: 2];
            elig[i] = (state == ST_ACTIVE) && !src_empty[i] && !dst_almost_full[cls[i]];
        end
    end

    // Round-robin scan starting just after the last granted source.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr;
        for (int k = 1; k <= FIFO_UNITS; k++) begin
            if (!grant_vld && elig[2'(ptr + 2'(k))]) begin
                grant_vld = 1'b1;
                grant_idx = 2'(ptr + 2'(k));
            end
        end
        grant_word = src_data[grant_idx*WORD_SIZE +: WORD_SIZE];
        src_pop    = grant_vld ? onehot(grant_idx) : '0;
    end

    assign cfg_valid = (umbral_IN_L < umbral_IN_H);

    // Error sources: a push landing on a full FIFO (almost-full margin was too
    // small) or an inconsistent threshold pair presented during INIT.
    assign err_set = (|(dst_full & dst_push)) || ((state == ST_INIT) && !cfg_valid);

    always_comb begin
        next_state = state;
        case (state)
            ST_RESET:  if (init) next_state = ST_INIT;
            ST_INIT:   if (!init) next_state = ST_IDLE;
            ST_IDLE: begin
                if (init)                      next_state = ST_INIT;
                else if (src_empty != 4'b1111) next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // Leave only once the last in-flight push has drained.
                if (init)                                          next_state = ST_INIT;
                else if ((src_empty == 4'b1111) && (dst_push == '0)) next_state = ST_IDLE;
            end
            default:   next_state = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= ST_RESET;
            ptr          <= 2'd3;
            dst_push     <= '0;
            dst_data     <= '0;
            umbral_H_out <= UMBRAL_H_RST;
            umbral_L_out <= UMBRAL_L_RST;
            active_out   <= 1'b0;
            idle_out     <= 1'b0;
            error_out    <= 1'b0;
        end else begin
            state      <= next_state;
            active_out <= (next_state == ST_ACTIVE);
            idle_out   <= (next_state == ST_IDLE);
            if (err_set) error_out <= 1'b1;

            if ((state == ST_INIT) && cfg_valid) begin
                umbral_H_out <= umbral_IN_H;
                umbral_L_out <= umbral_IN_L;
            end

            // pop -> push boundary: the granted word lands one cycle later
            if (grant_vld) begin
                ptr      <= grant_idx;
                dst_push <= onehot(grant_word[WORD_SIZE-1 -: 2]);
                dst_data <= grant_word;
            end else begin
                dst_push <= '0;
            end
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_tl_vc_arbiter.sv
// Directed testbench for tl_vc_arbiter: configuration, threshold error,
// round-robin order, blocked-destination bypass, single-word drain,
// asynchronous reset mid-transfer, and push-into-full error.

module tb_tl_vc_arbiter;

    localparam int WORD_SIZE  = 10;
    localparam int PTR_L      = 3;
    localparam int FIFO_UNITS = 4;

    logic                            clk = 1'b0;
    logic                            reset_L;
    logic                            init;
    logic [PTR_L-1:0]                umbral_IN_H;
    logic [PTR_L-1:0]                umbral_IN_L;
    logic [FIFO_UNITS-1:0]           src_empty;
    logic [FIFO_UNITS*WORD_SIZE-1:0] src_data;
    logic [FIFO_UNITS-1:0]           dst_almost_full;
    logic [FIFO_UNITS-1:0]           dst_full;
    logic [FIFO_UNITS-1:0]           src_pop;
    logic [FIFO_UNITS-1:0]           dst_push;
    logic [WORD_SIZE-1:0]            dst_data;
    logic [PTR_L-1:0]                umbral_H_out;
    logic [PTR_L-1:0]                umbral_L_out;
    logic [1:0]                      state_out;
    logic                            active_out;
    logic                            idle_out;
    logic                            error_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WORD_SIZE-1:0] rr_word [FIFO_UNITS];

    tl_vc_arbiter #(
        .WORD_SIZE (WORD_SIZE),
        .PTR_L     (PTR_L),
        .FIFO_UNITS(FIFO_UNITS)
    ) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .umbral_IN_H    (umbral_IN_H),
        .umbral_IN_L    (umbral_IN_L),
        .src_empty      (src_empty),
        .src_data       (src_data),
        .dst_almost_full(dst_almost_full),
        .dst_full       (dst_full),
        .src_pop        (src_pop),
        .dst_push       (dst_push),
        .dst_data       (dst_data),
        .umbral_H_out   (umbral_H_out),
        .umbral_L_out   (umbral_L_out),
        .state_out      (state_out),
        .active_out     (active_out),
        .idle_out       (idle_out),
        .error_out      (error_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [PTR_L-1:0] h, input logic [PTR_L-1:0] l);
        init        = 1'b1;
        umbral_IN_H = h;
        umbral_IN_L = l;
        cyc();                      // RESET/IDLE -> INIT
        cyc();                      // INIT: thresholds sampled
        init = 1'b0;
        cyc();                      // INIT -> IDLE
    endtask

    initial begin
        reset_L         = 1'b1;
        init            = 1'b0;
        umbral_IN_H     = '0;
        umbral_IN_L     = '0;
        src_empty       = 4'b1111;
        src_data        = '0;
        dst_almost_full = '0;
        dst_full        = '0;
        #1 reset_L = 1'b0;
        #2;

        // Reset values
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_H",     32'(umbral_H_out), 32'd6);
        check("rst_L",     32'(umbral_L_out), 32'd1);
        check("rst_push",  32'(dst_push), 32'd0);
        check("rst_data",  32'(dst_data), 32'd0);
        check("rst_err",   32'(error_out), 32'd0);
        check("rst_pop",   32'(src_pop), 32'd0);
        #4 reset_L = 1'b1;
        cyc();
        check("stay_reset", 32'(state_out), 32'd0);

        // Invalid thresholds: L >= H keeps defaults and sets sticky error
        init = 1'b1; umbral_IN_H = 3'd2; umbral_IN_L = 3'd4;
        cyc();
        check("bad_state_init", 32'(state_out), 32'd1);
        cyc();
        check("bad_err",  32'(error_out), 32'd1);
        check("bad_H",    32'(umbral_H_out), 32'd6);
        check("bad_L",    32'(umbral_L_out), 32'd1);
        init = 1'b0;
        cyc();
        check("bad_idle",       32'(state_out), 32'd2);
        check("err_sticky",     32'(error_out), 32'd1);
        #2 reset_L = 1'b0;
        #1 check("err_clr_rst", 32'(error_out), 32'd0);
        reset_L = 1'b1;

        // Valid configuration H=5 L=2
        init = 1'b1; umbral_IN_H = 3'd5; umbral_IN_L = 3'd2;
        cyc();
        check("cfg_state_init", 32'(state_out), 32'd1);
        check("cfg_pop_init",   32'(src_pop), 32'd0);
        cyc();
        check("cfg_H", 32'(umbral_H_out), 32'd5);
        check("cfg_L", 32'(umbral_L_out), 32'd2);
        init = 1'b0;
        cyc();
        check("cfg_state_idle", 32'(state_out), 32'd2);
        check("cfg_idle_out",   32'(idle_out), 32'd1);
        check("cfg_err",        32'(error_out), 32'd0);

        // Round-robin across four class-0 sources
        rr_word[0] = 10'h011; rr_word[1] = 10'h022; rr_word[2] = 10'h033; rr_word[3] = 10'h0F4;
        src_data  = {rr_word[3], rr_word[2], rr_word[1], rr_word[0]};
        src_empty = 4'b0000;
        #1 check("rr_pop_idle", 32'(src_pop), 32'd0);
        cyc();
        check("rr_active",     32'(state_out), 32'd3);
        check("rr_active_out", 32'(active_out), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("rr_pop", 32'(src_pop), 32'd1 << (k % 4));
            cyc();
            check("rr_push", 32'(dst_push), 32'd1);
            check("rr_data", 32'(dst_data), 32'(rr_word[k % 4]));
        end
        src_empty = 4'b1111;
        #1 check("rr_pop_empty", 32'(src_pop), 32'd0);
        cyc();
        check("rr_push_drain", 32'(dst_push), 32'd0);
        check("rr_still_act",  32'(state_out), 32'd3);
        cyc();
        check("rr_back_idle",  32'(state_out), 32'd2);

        // Blocked source: fifo1 -> class 2 almost full, fifo2 -> class 1
        src_data        = {10'h000, 10'h000, 10'h155, 10'h2AA};
        dst_almost_full = 4'b0100;
        src_empty       = 4'b1100;
        cyc();
        check("blk_pop_f2",  32'(src_pop), 32'b0010);
        cyc();
        check("blk_push_f2", 32'(dst_push), 32'b0010);
        check("blk_data_f2", 32'(dst_data), 32'h155);
        src_empty = 4'b1110;
        #1 check("blk_pop_none", 32'(src_pop), 32'd0);
        cyc();
        check("blk_push_none", 32'(dst_push), 32'd0);
        dst_almost_full = 4'b0000;
        #1 check("blk_pop_f1", 32'(src_pop), 32'b0001);
        cyc();
        check("blk_push_f1", 32'(dst_push), 32'b0100);
        check("blk_data_f1", 32'(dst_data), 32'h2AA);
        src_empty = 4'b1111;
        cyc();
        cyc();
        check("blk_idle", 32'(state_out), 32'd2);

        // Single word in fifo3, class 3
        src_data  = {10'h000, 10'h3C3, 10'h000, 10'h000};
        src_empty = 4'b1011;
        #1 check("one_pop_idle", 32'(src_pop), 32'd0);
        cyc();
        check("one_active", 32'(state_out), 32'd3);
        check("one_pop",    32'(src_pop), 32'b0100);
        cyc();
        src_empty = 4'b1111;
        check("one_push", 32'(dst_push), 32'b1000);
        check("one_data", 32'(dst_data), 32'h3C3);
        cyc();
        check("one_push_off", 32'(dst_push), 32'd0);
        cyc();
        check("one_idle",     32'(state_out), 32'd2);
        check("one_idle_out", 32'(idle_out), 32'd1);
        check("one_act_out",  32'(active_out), 32'd0);

        // Asynchronous reset while a push is pending
        src_data  = {10'h000, 10'h000, 10'h000, 10'h0A5};
        src_empty = 4'b1110;
        cyc();
        check("ar_pop", 32'(src_pop), 32'b0001);
        cyc();
        check("ar_push", 32'(dst_push), 32'b0001);
        src_empty = 4'b1111;
        #2 reset_L = 1'b0;
        #1;
        check("ar_push_drop", 32'(dst_push), 32'd0);
        check("ar_state",     32'(state_out), 32'd0);
        check("ar_data",      32'(dst_data), 32'd0);
        reset_L = 1'b1;

        // Push into a full destination flags an error
        configure(3'd5, 3'd2);
        check("full_idle", 32'(state_out), 32'd2);
        dst_full  = 4'b0001;
        src_empty = 4'b1110;
        cyc();
        check("full_err_pre", 32'(error_out), 32'd0);
        cyc();
        check("full_push",    32'(dst_push), 32'b0001);
        check("full_err_mid", 32'(error_out), 32'd0);
        src_empty = 4'b1111;
        cyc();
        check("full_err", 32'(error_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_vc_arbiter.md
Name: tl_vc_arbiter

Overview:
- Scheduler between the four transaction-layer source FIFOs (fifo1..fifo4) and the four destination FIFOs (fifo5..fifo8).
- Each cycle it picks one non-empty source by round-robin and pops its head word. It routes the word to the destination class in the word's top two bits, and issues no pop whose destination FIFO is almost full.
- It also holds the FIFO threshold configuration (umbral H/L), loaded during init.
- It sits between the input FIFO bank and the output FIFO bank, replacing the probador-driven rd/wr sequencing.

Parameters:
- WORD_SIZE, 10, data word width; bits [WORD_SIZE-1:WORD_SIZE-2] are the destination class (0..3 -> fifo5..fifo8).
- PTR_L, 3, threshold width; matches the FIFO pointer width.
- FIFO_UNITS, 4, number of source and destination FIFOs; fixed at 4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_L  in  1  asynchronous active-low reset.
- init  in  1  configuration request; level-sensitive.
- umbral_IN_H  in  PTR_L  almost-full threshold to load.
- umbral_IN_L  in  PTR_L  almost-empty threshold to load.
- src_empty  in  4  empty flags of fifo1..fifo4 (bit i = fifo(i+1)).
- src_data  in  4*WORD_SIZE  head words of fifo1..fifo4, first-word-fall-through; slice i = fifo(i+1).
- dst_almost_full  in  4  almost_full flags of fifo5..fifo8.
- dst_full  in  4  full flags of fifo5..fifo8.
- src_pop  out  4  one-hot read strobe to fifo1..fifo4; combinational.
- dst_push  out  4  one-hot write strobe to fifo5..fifo8; registered.
- dst_data  out  WORD_SIZE  word written with dst_push; registered.
- umbral_H_out  out  PTR_L  active almost-full threshold.
- umbral_L_out  out  PTR_L  active almost-empty threshold.
- state_out  out  2  FSM state: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE.
- active_out  out  1  high in ACTIVE.
- idle_out  out  1  high in IDLE.
- error_out  out  1  sticky error flag.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=RESET; src_pop=0, dst_push=0, dst_data=0.
  - umbral_H_out=3'd6, umbral_L_out=3'd1; active_out=0, idle_out=0, error_out=0.
  - RR pointer = 3, so source 0 has first priority.
  - A reset mid-transfer drops any pending push.
- RESET -> INIT when init=1; otherwise stay in RESET. No pops in RESET.
- INIT:
  - Every cycle, if umbral_IN_L < umbral_IN_H, load both thresholds (visible the next cycle).
  - Otherwise keep the old values and set error_out.
  - INIT -> IDLE when init=0.
  - No pops in INIT; a push registered on the previous cycle still completes.
- IDLE -> ACTIVE when src_empty != 4'b1111.
- IDLE or ACTIVE -> INIT when init=1; this has priority over all other transitions.
- ACTIVE -> IDLE when src_empty==4'b1111 and dst_push==0.
- Eligibility (ACTIVE only): source i is eligible iff src_empty[i]==0 and dst_almost_full[d_i]==0, where d_i = src_data slice i [WORD_SIZE-1:WORD_SIZE-2].
- Grant:
  - g is the first eligible index scanning ptr+1, ptr+2, ... mod 4.
  - src_pop = onehot(g) in the same cycle; src_pop=0 if no source is eligible.
  - On the clock edge: ptr<=g, dst_push<=onehot(d_g), dst_data<=the granted word. Latency from pop to push is 1 cycle.
  - Cycles without a grant: dst_push<=0; dst_data holds its value.
- Throughput: at most 1 word per cycle total. Back-to-back grants are allowed, including to the same source.
- Blocked source: an ineligible source does not move ptr and does not block other eligible sources (no head-of-line blocking across sources).
- Almost-full margin: dst_almost_full must cover the one in-flight word. If dst_full[k]==1 in a cycle where dst_push[k]==1, set error_out; the push is still issued.
- Sticky error: error_out clears only on reset.
- Status decode: active_out=(state==ACTIVE) and idle_out=(state==IDLE), both registered with the state.

Test Plan:
- Reset then init=1 with H=5, L=2 for 2 cycles, then init=0 -> umbral_H_out=5, umbral_L_out=2, state goes INIT then IDLE, error_out=0, no src_pop.
- init with H=2, L=4 -> thresholds stay at 6/1, error_out=1, and it stays 1 until reset_L pulses low.
- All four sources non-empty, each with class 0, dst_almost_full=0 -> src_pop sequence 0001, 0010, 0100, 1000, 0001; dst_push=0001 one cycle after each pop; dst_data equals the popped word.
- fifo1 head class 2 with dst_almost_full[2]=1, fifo2 head class 1 -> only fifo2 is popped; fifo1 is popped on the first cycle after dst_almost_full[2] falls, then dst_push=0100.
- Single word in fifo3 -> IDLE to ACTIVE, one pop, push one cycle later, then back to IDLE with idle_out=1.
- Assert reset_L=0 asynchronously in the cycle after a pop -> dst_push drops to 0 immediately and state=RESET.
